// File: rtl/vc_fifo_pkg.sv
// Shared sizing constants for the per-virtual-channel FIFO and its storage array.
// The VC stage may override these through the module parameters.
package vc_fifo_pkg;

    localparam int VC_BW    = 6;
    localparam int VC_DEPTH = 4;
    localparam int VC_AW    = $clog2(VC_DEPTH);
    localparam int VC_CW    = VC_AW + 1;

endpackage

// File: rtl/vc_fifo_mem.sv
// DEPTH x BW register array: synchronous write port, asynchronous read port.
// Contents are never reset; the FIFO control logic tracks which entries are live.
module vc_fifo_mem
    import vc_fifo_pkg::*;
#(
    parameter int BW    = VC_BW,
    parameter int DEPTH = VC_DEPTH,
    parameter int AW    = VC_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vc_fifo.sv
// Per-VC buffer behind the VC-ID demux: pointers, occupancy, QoS flags,
// registered read port and a sticky overflow flag around a vc_fifo_mem array.
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int BW    = VC_BW,
    parameter int DEPTH = VC_DEPTH,
    parameter int AW    = VC_AW,
    parameter int CW    = VC_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [BW-1:0] data_in,
    input  logic          pop,
    input  logic [CW-1:0] umbral_af,
    input  logic [CW-1:0] umbral_ae,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          fifo_error,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          fifo_error_q, fifo_error_d;

    logic          push_ok;
    logic          pop_ok;
    logic          is_full;
    logic          is_empty;
    logic [BW-1:0] mem_rdata;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // A pop on a full FIFO frees a slot in the same edge, so a push is still taken.
    assign pop_ok  = pop & ~is_empty;
    assign push_ok = valid_in & (~is_full | pop_ok);

    vc_fifo_mem #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        fifo_error_d = fifo_error_q;
        count_d      = count_q + {{(CW-1){1'b0}}, push_ok}
                               - {{(CW-1){1'b0}}, pop_ok};

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            data_out_d  = mem_rdata;
            valid_out_d = 1'b1;
        end

        // Only a push into a full FIFO with no companion pop is dropped.
        if (valid_in && !push_ok) begin
            fifo_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            fifo_error_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            fifo_error_q <= fifo_error_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign fifo_error   = fifo_error_q;
    assign count        = count_q;
    assign fifo_full    = is_full;
    assign fifo_empty   = is_empty;
    assign almost_full  = (count_q >= umbral_af);
    assign almost_empty = (count_q <= umbral_ae);

endmodule

// File: tb/tb_vc_fifo.sv
// Randomised and directed bench for vc_fifo: a queue-based reference model
// predicts state each cycle and feeds a scoreboard drained by an output monitor.
module tb_vc_fifo;

    localparam int BW    = 6;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 3;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic [BW-1:0] data_in;
    logic          pop;
    logic [CW-1:0] umbral_af;
    logic [CW-1:0] umbral_ae;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic          fifo_error;
    logic [CW-1:0] count;

    vc_fifo #(
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .pop          (pop),
        .umbral_af    (umbral_af),
        .umbral_ae    (umbral_ae),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int numCompared = 0;
    int numMismatched = 0;

    // Reference model: the stored words as a queue, plus the registered outputs.
    int modelQueue[$];
    int modelData = 0;
    bit modelValid = 1'b0;
    bit modelError = 1'b0;

    // Words the DUT must present on data_out, in order.
    int scoreboard[$];

    function automatic void compare(input string name, input int actual, input int expected);
        numCompared++;
        if (actual != expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endfunction

    task automatic checkOutput();
        int size;
        size = modelQueue.size();
        compare("count",        int'(count),        size);
        compare("fifo_full",    int'(fifo_full),    int'(size == DEPTH));
        compare("fifo_empty",   int'(fifo_empty),   int'(size == 0));
        compare("almost_full",  int'(almost_full),  int'(size >= int'(umbral_af)));
        compare("almost_empty", int'(almost_empty), int'(size <= int'(umbral_ae)));
        compare("fifo_error",   int'(fifo_error),   int'(modelError));
        compare("valid_out",    int'(valid_out),    int'(modelValid));
        compare("data_out",     int'(data_out),     modelData);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic applyStimulus(input bit rst, input bit vin, input int din, input bit popReq);
        bit popOk;
        bit pushOk;
        reset    = rst;
        valid_in = vin;
        data_in  = BW'(din);
        pop      = popReq;
        if (rst) begin
            modelQueue.delete();
            modelData  = 0;
            modelValid = 1'b0;
            modelError = 1'b0;
        end else begin
            popOk  = popReq && (modelQueue.size() > 0);
            pushOk = vin && ((modelQueue.size() < DEPTH) || popOk);
            if (vin && !pushOk) modelError = 1'b1;
            modelValid = popOk;
            if (popOk) begin
                modelData = modelQueue.pop_front();
                scoreboard.push_back(modelData);
            end
            if (pushOk) modelQueue.push_back(din & 'h3F);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    // Output monitor: every valid_out pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (scoreboard.size() == 0) begin
                compare("unexpected_output", int'(data_out), -1);
            end else begin
                compare("sb_data", int'(data_out), scoreboard.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        pop       = 1'b0;
        umbral_af = 3'd3;
        umbral_ae = 3'd1;

        $display("[TB] basic push/pop");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 'h01, 0);
        applyStimulus(0, 1, 'h02, 0);
        applyStimulus(0, 1, 'h03, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] threshold flags");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 'h20 + i, 0);

        $display("[TB] overflow");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 'h0A + i, 0);
        applyStimulus(0, 1, 'h3F, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] push and pop while full");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 'h10 + i, 0);
        applyStimulus(0, 1, 'h15, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

        $display("[TB] empty corner cases");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 'h2A, 1);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] wrap-around and mid-run reset");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, i, 0);
            applyStimulus(0, 0, 0, 1);
        end
        applyStimulus(0, 1, 'h31, 0);
        applyStimulus(0, 1, 'h32, 0);
        applyStimulus(1, 1, 'h33, 1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                umbral_af = CW'($urandom_range(0, 7));
                umbral_ae = CW'($urandom_range(0, 7));
            end
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 99) < 60,
                          int'($urandom_range(0, 63)),
                          $urandom_range(0, 99) < 50);
        end
        applyStimulus(0, 0, 0, 0);

        compare("scoreboard_drained", scoreboard.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
